// File: rtl/rx_pkt_pkg.sv
// Shared constants and FSM state encoding for the rx packet parser.
// Pure declarations: no logic, no latency, no flow control.
package rx_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         MAX_LEN_DEF = 8;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_CMD  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } state_e;

endpackage

// File: rtl/rx_byte_fetch.sv
// Byte fetch from the rx FIFO: combinational pop when count != 0, then one forced wait cycle.
// Zero latency to the parser; at most one byte per two cycles; empty FIFO simply stalls.
module rx_byte_fetch #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    input  logic [7:0]       fifo_byte_i,
    output logic             fifo_pop_o,
    output logic             byte_vld_o,
    output logic [7:0]       byte_dat_o
);

    logic wait_q;
    logic wait_d;

    // Gated by reset so no pop leaks out while the parser is held.
    assign byte_vld_o = !rst_i && !wait_q && (fifo_cnt_i != '0);
    assign fifo_pop_o = byte_vld_o;
    assign byte_dat_o = fifo_byte_i;
    assign wait_d     = byte_vld_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/rx_pkt_parser.sv
// Frame parser (A5 CMD LEN payload [CHK]); outputs register on the edge consuming the last byte.
// Stalls on an empty FIFO; optional checksum byte when RX_PKT_CHKSUM_EN is defined.
module rx_pkt_parser
    import rx_pkt_pkg::*;
#(
    parameter int CNT_W   = 5,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            FIFO_RD,
    output logic                   FIFO_POP,
    output logic [7:0]             PKT_CMD,
    output logic [3:0]             PKT_LEN,
    output logic [8*MAX_LEN-1:0]   PKT_DATA,
    output logic                   PKT_VALID,
    output logic [7:0]             ERR_CNT
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic                 byte_vld;
    logic [7:0]           byte_dat;
    logic                 unused_rd_bits;

    state_e               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [3:0]           len_q, len_d;
    logic [3:0]           idx_q, idx_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d;
    logic                 commit;
    logic                 err_inc;
`ifdef RX_PKT_CHKSUM_EN
    logic [7:0]           chk_q, chk_d;
`endif

    logic [7:0]           pkt_cmd_q;
    logic [3:0]           pkt_len_q;
    logic [8*MAX_LEN-1:0] pkt_data_q;
    logic                 pkt_valid_q;
    logic [7:0]           err_cnt_q;

    assign unused_rd_bits = ^{FIFO_RD[31:16+CNT_W], FIFO_RD[15:8]};

    rx_byte_fetch #(
        .CNT_W (CNT_W)
    ) u_fetch (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .fifo_cnt_i  (FIFO_RD[16+CNT_W-1:16]),
        .fifo_byte_i (FIFO_RD[7:0]),
        .fifo_pop_o  (FIFO_POP),
        .byte_vld_o  (byte_vld),
        .byte_dat_o  (byte_dat)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        commit  = 1'b0;
        err_inc = 1'b0;
`ifdef RX_PKT_CHKSUM_EN
        chk_d   = chk_q;
`endif
        if (byte_vld) begin
            case (state_q)
                ST_SYNC: begin
                    if (byte_dat == SYNC_BYTE) state_d = ST_CMD;
                end
                ST_CMD: begin
                    cmd_d   = byte_dat;
`ifdef RX_PKT_CHKSUM_EN
                    chk_d   = byte_dat;
`endif
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    // Clearing the working buffer here gives zero-fill above LEN for free.
                    idx_d = '0;
                    buf_d = '0;
                    if (byte_dat > MAX_LEN_B) begin
                        err_inc = 1'b1;
                        state_d = ST_SYNC;
                    end else begin
                        len_d = byte_dat[3:0];
`ifdef RX_PKT_CHKSUM_EN
                        chk_d = chk_q ^ byte_dat;
`endif
                        if (byte_dat == 8'd0) begin
`ifdef RX_PKT_CHKSUM_EN
                            state_d = ST_CHK;
`else
                            commit  = 1'b1;
                            state_d = ST_SYNC;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    buf_d[8*int'(idx_q) +: 8] = byte_dat;
                    idx_d = idx_q + 4'd1;
`ifdef RX_PKT_CHKSUM_EN
                    chk_d = chk_q ^ byte_dat;
`endif
                    if ((idx_q + 4'd1) == len_q) begin
`ifdef RX_PKT_CHKSUM_EN
                        state_d = ST_CHK;
`else
                        commit  = 1'b1;
                        state_d = ST_SYNC;
`endif
                    end
                end
`ifdef RX_PKT_CHKSUM_EN
                ST_CHK: begin
                    if (byte_dat == chk_q) commit  = 1'b1;
                    else                   err_inc = 1'b1;
                    state_d = ST_SYNC;
                end
`endif
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_SYNC;
            cmd_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
`ifdef RX_PKT_CHKSUM_EN
            chk_q       <= '0;
`endif
            pkt_cmd_q   <= '0;
            pkt_len_q   <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
`ifdef RX_PKT_CHKSUM_EN
            chk_q       <= chk_d;
`endif
            pkt_valid_q <= commit;
            if (commit) begin
                pkt_cmd_q  <= cmd_d;
                pkt_len_q  <= len_d;
                pkt_data_q <= buf_d;
            end
            if (err_inc && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign PKT_CMD   = pkt_cmd_q;
    assign PKT_LEN   = pkt_len_q;
    assign PKT_DATA  = pkt_data_q;
    assign PKT_VALID = pkt_valid_q;
    assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_rx_pkt_parser.sv
// Directed bench for rx_pkt_parser: queue-backed FIFO model, hand-computed expectations.
// Expectations follow RX_PKT_CHKSUM_EN when the bench is built with it.
module tb_rx_pkt_parser;

    localparam int CNT_W   = 5;
    localparam int MAX_LEN = 8;

    logic                 CLK     = 1'b0;
    logic                 RESET   = 1'b1;
    logic [31:0]          FIFO_RD = 32'h0000_EEA5;
    logic                 FIFO_POP;
    logic [7:0]           PKT_CMD;
    logic [3:0]           PKT_LEN;
    logic [8*MAX_LEN-1:0] PKT_DATA;
    logic                 PKT_VALID;
    logic [7:0]           ERR_CNT;

    logic [7:0] q[$];
    bit         hold     = 1'b0;
    bit         pop_seen = 1'b0;
    bit         prev_pop = 1'b0;
    int         pops     = 0;
    int         vld_cnt  = 0;
    int         consec   = 0;
    int         vecs     = 0;
    int         errs     = 0;
    int         exp_vld  = 0;
    int         exp_err  = 0;
    int         pops_before;

    rx_pkt_parser #(
        .CNT_W   (CNT_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .FIFO_RD   (FIFO_RD),
        .FIFO_POP  (FIFO_POP),
        .PKT_CMD   (PKT_CMD),
        .PKT_LEN   (PKT_LEN),
        .PKT_DATA  (PKT_DATA),
        .PKT_VALID (PKT_VALID),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] fifo_word();
        int n;
        n = hold ? 0 : ((q.size() > 31) ? 31 : q.size());
        return {11'h5A5, 5'(n), 8'hEE, (q.size() != 0) ? q[0] : 8'hA5};
    endfunction

    // Pop strobe sampled mid-cycle; the FIFO model retires the head just after the edge.
    always @(negedge CLK) begin
        pop_seen = FIFO_POP;
        if (FIFO_POP && prev_pop) consec++;
        prev_pop = FIFO_POP;
        if (FIFO_POP) pops++;
        if (PKT_VALID) vld_cnt++;
    end

    always @(posedge CLK) begin
        #1;
        if (pop_seen && (q.size() != 0)) q.delete(0);
        FIFO_RD = fifo_word();
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    task automatic send(input int n, input logic [127:0] v);
        for (int k = 0; k < n; k++) q.push_back(v[8*(n-1-k) +: 8]);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && q.size() != 0; i++) tick();
        repeat (3) tick();
        check_vec({tag, "_drain"}, 64'(q.size()), 64'd0);
    endtask

    task automatic check_out(input string tag, input logic [7:0] cmd, input logic [3:0] len,
                             input logic [63:0] data);
        check_vec({tag, "_cmd"},  64'(PKT_CMD),  64'(cmd));
        check_vec({tag, "_len"},  64'(PKT_LEN),  64'(len));
        check_vec({tag, "_data"}, PKT_DATA,      data);
        check_vec({tag, "_nvld"}, 64'(vld_cnt),  64'(exp_vld));
        check_vec({tag, "_err"},  64'(ERR_CNT),  64'(exp_err));
    endtask

    initial begin
        q.push_back(8'h00);
        repeat (3) tick();
        check_vec("rst_pop", 64'(pops), 64'd0);
        check_out("rst", 8'h00, 4'd0, 64'h0);
        RESET = 1'b0;

        send(6, 48'hA5_10_02_11_22_21);
        drain("good");
        exp_vld++;
        check_out("good", 8'h10, 4'd2, 64'h2211);

        send(6, 48'h00_FF_A5_05_00_05);
        drain("len0");
        exp_vld++;
        check_out("len0", 8'h05, 4'd0, 64'h0);

        send(5, 40'hA5_10_01_33_00);
        drain("badchk");
`ifdef RX_PKT_CHKSUM_EN
        exp_err++;
        check_out("badchk", 8'h05, 4'd0, 64'h0);
`else
        exp_vld++;
        check_out("badchk", 8'h10, 4'd1, 64'h33);
`endif

        send(5, 40'hA5_20_01_A5_84);
        drain("a5data");
        exp_vld++;
        check_out("a5data", 8'h20, 4'd1, 64'hA5);

        send(3, 24'hA5_10_09);
        drain("toolong");
        exp_err++;
        check_out("toolong", 8'h20, 4'd1, 64'hA5);

        send(12, 96'hA5_50_08_01_02_03_04_05_06_07_08_50);
        drain("maxlen");
        exp_vld++;
        check_out("maxlen", 8'h50, 4'd8, 64'h0807060504030201);

        send(4, 32'hA5_10_02_11);
        drain("partial");
        RESET = 1'b1;
        tick();
        check_vec("midrst_vld", 64'(PKT_VALID), 64'd0);
        check_vec("midrst_pop", 64'(FIFO_POP), 64'd0);
        RESET = 1'b0;
        exp_err = 0;
        check_out("midrst", 8'h00, 4'd0, 64'h0);

        send(7, 56'hA5_30_03_01_02_03_33);
        drain("afterrst");
        exp_vld++;
        check_out("afterrst", 8'h30, 4'd3, 64'h030201);

        send(5, 40'hA5_40_01_77_36);
        drain("zfill");
        exp_vld++;
        check_out("zfill", 8'h40, 4'd1, 64'h77);

        for (int i = 0; i < 256; i++) send(3, 24'hA5_10_09);
        drain("sat");
        exp_err = 255;
        check_out("sat", 8'h40, 4'd1, 64'h77);

        pops_before = pops;
        hold = 1'b1;
        send(3, 24'hA5_10_09);
        repeat (12) tick();
        check_vec("hold_pops", 64'(pops), 64'(pops_before));
        check_vec("hold_pop",  64'(FIFO_POP), 64'd0);
        hold = 1'b0;
        drain("sathold");
        check_vec("sathold_err", 64'(ERR_CNT), 64'd255);

        check_vec("consec_pop", 64'(consec), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
